dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Handshaked data-memory responder; the memory side of the core's load/store interface (byte address, write enable, funct3 size/sign select, write data, read data).
- Replaces the zero-latency data memory with a valid/ready request/response slave that has configurable wait states, so the pipelined core can be verified against a memory that stalls.
- Holds a word-organised RAM and performs LB/LH/LW/LBU/LHU/SB/SH/SW with the RV32I size and sign rules.

Parameters:
- ADDR_W, 8: byte-address width.
- DEPTH_WORDS, 64: number of 32-bit words; valid byte addresses are 0 to DEPTH_WORDS*4-1.
- WAIT_CYCLES, 1: wait-state cycles between request acceptance and response, 0 to 15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low byte/half/word used according to size.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors.
- rsp_err  out  1  access was rejected.

Behaviour:
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake on clk when req_valid&req_ready: latch write, funct3, addr and wdata.
  - Go to WAIT if WAIT_CYCLES>0, otherwise perform the access and go to RESP.
- WAIT:
  - req_ready=0; a 4-bit counter counts WAIT_CYCLES cycles.
  - In the last WAIT cycle, perform the access and go to RESP.
  - Request-to-rsp_valid latency is WAIT_CYCLES+1 edges.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - When rsp_ready=1, go to IDLE; req_ready rises the next cycle (no same-cycle accept).
  - Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Access rules:
  - Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
  - LB/LBU select byte lane; LH/LHU select the half at addr[1]; LW returns the whole word.
  - B and H loads sign-extend; BU and HU loads zero-extend.
  - SB writes one byte lane, SH writes two lanes, SW writes four; other lanes are untouched.
- Error (rsp_err=1, no memory write, rsp_rdata=0) when any of these hold:
  - funct3 is 011, 110 or 111;
  - store with funct3 100 or 101;
  - H access with addr[0]=1;
  - W access with addr[1:0]!=0;
  - addr >= DEPTH_WORDS*4.
- Reset, assertable at any time including mid-transaction:
  - State goes to IDLE and the counter to 0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 once reset is released.
  - A pending store that has not yet been performed is dropped.
  - RAM contents are not reset.
- req_* inputs are ignored outside IDLE.
- rsp_ready is ignored outside RESP.

Optional Feature:
- Macro DMEM_ERR_EN.
- Defined: error checking exactly as in Behaviour.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned H/W accesses are forced aligned: addr[0] is cleared for H; addr[1:0] is cleared for W.
  - Out-of-range addresses wrap modulo DEPTH_WORDS.
  - Illegal funct3 values are treated as W.

Test Plan:
- WAIT_CYCLES=1. SW addr 0x10 data 0x8899AABB, then LW 0x10 -> rsp_valid 2 edges after each accept; rdata 0x8899AABB, err 0.
- After the above: LB 0x13 -> 0xFFFFFF88. LBU 0x13 -> 0x00000088. LH 0x10 -> 0xFFFFAABB. LHU 0x12 -> 0x00008899.
- SB 0x11 data 0x000000CC, then LW 0x10 -> 0x8899CCBB.
- SH 0x11 -> err 1; subsequent LW 0x10 still 0x8899CCBB. LW 0x100 with DEPTH_WORDS=64 -> err 1, rdata 0. Without DMEM_ERR_EN, SH 0x11 data 0x1234 -> LW 0x10 = 0x88991234.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stay stable and req_ready stays 0. With WAIT_CYCLES=0, latency is 1 edge.
- Assert reset during WAIT of an SW to 0x20 -> outputs return to reset values; after release, LW 0x20 returns its prior content (store dropped).

Source files
------------

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with configurable wait states and RV32I load/store sizing.
// Optional macro DMEM_ERR_EN enables access checking; when undefined, accesses are forced legal.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_op_write;
  logic [2:0]          w_op_funct3;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [31:0]         w_op_wdata;
  logic                w_illegal;
  logic                w_is_b;
  logic                w_is_h;
  logic                w_is_w;
  logic                w_uns;
  logic                w_err;
  logic [1:0]          w_lane;
  logic [IW-1:0]       w_widx;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_rdata;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata_rep;
  logic                w_do_access;
  logic                w_we;

  // With no wait states the access happens on the handshake edge, so it must use the live request.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_op_write  = req_write;
      w_op_funct3 = req_funct3;
      w_op_addr   = req_addr;
      w_op_wdata  = req_wdata;
    end else begin
      w_op_write  = r_write;
      w_op_funct3 = r_funct3;
      w_op_addr   = r_addr;
      w_op_wdata  = r_wdata;
    end
  end

  always_comb begin
    w_illegal = (w_op_funct3 == 3'b011) || (w_op_funct3[2:1] == 2'b11);
    w_uns     = w_op_funct3[2] && !w_illegal;
`ifdef DMEM_ERR_EN
    w_is_b = (w_op_funct3[1:0] == 2'b00);
    w_is_h = (w_op_funct3[1:0] == 2'b01);
    w_is_w = (w_op_funct3[1:0] == 2'b10);
    w_lane = w_op_addr[1:0];
    w_err  = w_illegal
          || (w_op_write && w_op_funct3[2])
          || (w_is_h && w_op_addr[0])
          || (w_is_w && (w_op_addr[1:0] != 2'b00))
          || (32'(w_op_addr) >= 32'(DEPTH_WORDS * 4));
`else
    w_is_b = !w_illegal && (w_op_funct3[1:0] == 2'b00);
    w_is_h = !w_illegal && (w_op_funct3[1:0] == 2'b01);
    w_is_w = w_illegal || (w_op_funct3[1:0] == 2'b10);
    if (w_is_h)      w_lane = {w_op_addr[1], 1'b0};
    else if (w_is_w) w_lane = 2'b00;
    else             w_lane = w_op_addr[1:0];
    w_err  = 1'b0;
`endif
    w_widx = IW'(32'(w_op_addr[ADDR_W-1:2]) % 32'(DEPTH_WORDS));
    w_word = r_mem[w_widx];
    w_byte = w_word[{w_lane, 3'b000} +: 8];
    w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    if (w_is_b)      w_load = {{24{!w_uns && w_byte[7]}}, w_byte};
    else if (w_is_h) w_load = {{16{!w_uns && w_half[15]}}, w_half};
    else             w_load = w_word;
    w_rdata = (w_err || w_op_write) ? '0 : w_load;

    if (w_is_b) begin
      w_be        = 4'b0001 << w_lane;
      w_wdata_rep = {4{w_op_wdata[7:0]}};
    end else if (w_is_h) begin
      w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wdata_rep = {2{w_op_wdata[15:0]}};
    end else begin
      w_be        = 4'b1111;
      w_wdata_rep = w_op_wdata;
    end
  end

  assign w_do_access = reset &&
                       (((r_state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == LAST_WAIT)));
  assign w_we = w_do_access && w_op_write && !w_err;

  // RAM has no reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rdata;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == LAST_WAIT) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (one and zero wait states) against a byte-array model.
// Follows DMEM_ERR_EN the same way the design does.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_err;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

  int nvec = 0;
  int nmis = 0;
  logic [7:0] mdl [2][256];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .DEPTH_WORDS(64), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rdata1), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.ADDR_W(10), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rdata0), .rsp_err(rsp_err[0])
  );

  function automatic logic [31:0] get_rdata(input int s);
    return (s == 1) ? rdata1 : rdata0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array, access sized in bytes.
  task automatic ref_access(input int s, input bit wr, input logic [2:0] f3, input int a_in,
                            input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int a = a_in;
    int size;
    bit uns;
    bit illegal;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    uns  = f3[2];
`ifdef DMEM_ERR_EN
    err = illegal || (wr && uns) || (a % size != 0) || (a >= 256);
`else
    err = 1'b0;
    if (illegal) begin
      size = 4;
      uns  = 1'b0;
    end
    a = a - (a % size);
    a = a % 256;
`endif
    rd = '0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mdl[s][a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = mdl[s][a+i];
        if (!uns && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
      end
    end
  endtask

  task automatic txn(input int s, input bit wr, input logic [2:0] f3, input logic [9:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output bit er);
    int lat;
    bit eerr;
    logic [31:0] erd;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[s]), 32'd1);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid[s] = 1'b1;
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_addr     = 10'($urandom);
    req_wdata    = $urandom;
    lat = 1;
    while (!rsp_valid[s] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), (s == 1) ? 32'd2 : 32'd1);
    ref_access(s, wr, f3, int'(a), wd, eerr, erd);
    rd = get_rdata(s);
    er = rsp_err[s];
    chk("rdata", rd, erd);
    chk("err", 32'(er), 32'(eerr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
      chk("hold_rdata", get_rdata(s), erd);
      chk("hold_err", 32'(rsp_err[s]), 32'(eerr));
      chk("hold_req_ready", 32'(req_ready[s]), 32'd0);
    end
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid[s]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    logic [2:0] f3;
    bit wr;
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_write = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid1", 32'(rsp_valid[1]), 32'd0);
    chk("rst_rsp_err1", 32'(rsp_err[1]), 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_rsp_valid0", 32'(rsp_valid[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_req_ready1", 32'(req_ready[1]), 32'd1);
    chk("rel_req_ready0", 32'(req_ready[0]), 32'd1);

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 64; w++) txn(s, 1'b1, 3'b010, 10'(4*w), $urandom, 0, rd, er);

    txn(1, 1'b1, 3'b010, 10'h010, 32'h8899AABB, 0, rd, er);
    chk("sw_err", 32'(er), 32'd0);
    txn(1, 1'b0, 3'b010, 10'h010, 32'h0, 0, rd, er);
    chk("lw_10", rd, 32'h8899AABB);
    chk("lw_10_err", 32'(er), 32'd0);
    txn(1, 1'b0, 3'b000, 10'h013, 32'h0, 0, rd, er);
    chk("lb_13", rd, 32'hFFFFFF88);
    txn(1, 1'b0, 3'b100, 10'h013, 32'h0, 0, rd, er);
    chk("lbu_13", rd, 32'h00000088);
    txn(1, 1'b0, 3'b001, 10'h010, 32'h0, 0, rd, er);
    chk("lh_10", rd, 32'hFFFFAABB);
    txn(1, 1'b0, 3'b101, 10'h012, 32'h0, 0, rd, er);
    chk("lhu_12", rd, 32'h00008899);
    txn(1, 1'b1, 3'b000, 10'h011, 32'h000000CC, 0, rd, er);
    txn(1, 1'b0, 3'b010, 10'h010, 32'h0, 0, rd, er);
    chk("lw_after_sb", rd, 32'h8899CCBB);
    txn(1, 1'b1, 3'b001, 10'h011, 32'h00001234, 0, rd, er);
`ifdef DMEM_ERR_EN
    chk("sh_mis_err", 32'(er), 32'd1);
    txn(1, 1'b0, 3'b010, 10'h010, 32'h0, 0, rd, er);
    chk("lw_after_bad_sh", rd, 32'h8899CCBB);
    txn(1, 1'b0, 3'b010, 10'h100, 32'h0, 0, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
`else
    chk("sh_mis_err", 32'(er), 32'd0);
    txn(1, 1'b0, 3'b010, 10'h010, 32'h0, 0, rd, er);
    chk("lw_after_forced_sh", rd, 32'h88991234);
    txn(1, 1'b0, 3'b010, 10'h100, 32'h0, 0, rd, er);
    chk("oor_err", 32'(er), 32'd0);
`endif
    txn(1, 1'b0, 3'b010, 10'h010, 32'h0, 5, rd, er);

    txn(0, 1'b1, 3'b010, 10'h040, 32'hCAFEF00D, 0, rd, er);
    txn(0, 1'b0, 3'b010, 10'h040, 32'h0, 0, rd, er);
    chk("w0_lw_40", rd, 32'hCAFEF00D);

    @(negedge clk);
    req_write = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 10'h020;
    req_wdata = 32'h5A5A5A5A;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err[1]), 32'd0);
    chk("midrst_rdata", rdata1, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_still_idle", 32'(rsp_valid[1]), 32'd0);
    txn(1, 1'b0, 3'b010, 10'h020, 32'h0, 0, rd, er);

    for (int n = 0; n < 240; n++) begin
      int s;
      s  = (n % 4 == 0) ? 0 : 1;
      wr = 1'($urandom);
      f3 = 3'($urandom);
`ifndef DMEM_ERR_EN
      if (wr && (f3 == 3'b100 || f3 == 3'b101)) f3 = 3'b010;
`endif
      txn(s, wr, f3, 10'($urandom_range(0, 299)), $urandom, $urandom_range(0, 2), rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
